fir_mac_coef_bank: RTL and testbench
====================================

// Module: fir_mac_coef_bank
// PURPOSE
//  Parametrised time-multiplexed FIR filter: one multiplier, one accumulator, TAPS MAC cycles per sample.
//  Double-buffered coefficient bank: new coefficients load serially (button/strobe driven) while the active bank keeps filtering.
//  The new bank swaps in atomically. Sits between the ADC sample source and the output FIFO.
//  Successor of the fixed 16-tap, 12-bit filter: width, depth and output scaling are generic.
// PARAMETERS
//  DATA_W   12  signed sample width
//  COEF_W   12  signed coefficient width
//  TAPS     16  number of taps (>=2); IDX_W = $clog2(TAPS)
//  OUT_W    16  signed output width
//  SHIFT    4   arithmetic right shift applied to accumulator before saturation
// PORTS
//  clk_100MHz_i       in   1        system clock, rising edge
//  rst_i              in   1        asynchronous reset, ACTIVE-LOW (0 = reset)
//  pulsador_carga_coef_i in 1       rising edge starts/restarts a coefficient load
//  cambio_coef_i      in   1        rising edge writes coef_in into shadow bank
//  coef_in            in   COEF_W   signed coefficient value
//  sample_valid_i     in   1        sample strobe, 1 cycle
//  sample_i           in   DATA_W   signed sample
//  ready_o            out  1        1 = next sample_valid_i is accepted
//  dato_o             out  OUT_W    signed filtered sample, held until next result
//  dato_valid_o       out  1        1-cycle strobe with each new dato_o
//  loading_o          out  1        1 while a coefficient load is in progress
//  coef_done_o        out  1        1-cycle strobe when the new bank becomes active
//  overrun_o          out  1        sticky: sample arrived while ready_o=0
// BEHAVIOUR
//  Reset (rst_i=0, async): delay line, both banks, accumulator = 0; FSM=IDLE; load FSM=L_IDLE.
//   ready_o=1, all other outputs 0. Before any load, output is 0 for any input.
//  Edge detect: one register per strobe input; an event is in=1 & prev=0.
//   A held level causes exactly one event. prev resets to 0.
//  Load FSM L_IDLE/L_LOAD:
//   load edge -> L_LOAD, idx=0, loading_o=1. A load edge in L_LOAD restarts at idx=0; partial shadow data is discarded.
//   Each cambio edge in L_LOAD: shadow[idx]=coef_in, idx++. Ignored in L_IDLE.
//   Write of idx=TAPS-1 -> swap_pend=1, back to L_IDLE.
//  Swap: on the first cycle with swap_pend=1 and MAC FSM in IDLE, active<=shadow (all taps at once).
//   Same cycle: swap_pend=0, coef_done_o=1.
//   A sample accepted in that same cycle uses the NEW bank.
//  MAC FSM IDLE/MAC/OUT:
//   IDLE: ready_o=1. On sample_valid_i: x[0]<=sample_i, x[k]<=x[k-1], acc=0, k=0 -> MAC, ready_o=0.
//   MAC: acc += x[k]*h[k] (h[0] pairs with newest sample); TAPS cycles; after k=TAPS-1 -> OUT.
//   OUT: dato_o<=sat(acc>>>SHIFT), dato_valid_o=1 -> IDLE.
//   Latency: accept at edge 0, dato_valid_o at edge TAPS+1. Max rate 1 sample / TAPS+2 cycles.
//  Widths: product DATA_W+COEF_W; acc DATA_W+COEF_W+IDX_W, no internal overflow.
//   Saturation clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  Overrun: sample_valid_i while ready_o=0 -> sample dropped, overrun_o=1 until reset.
//   Pipeline state is not disturbed.
//  Swap pending during MAC: current result uses the old bank; swap happens in the IDLE cycle after OUT.
//  Reset mid-MAC or mid-load: immediate abort; state returns to reset values; no dato_valid_o.
// TESTING
//  1 Reset: rst_i=0 for 10 cycles, mid-MAC -> all outputs 0, ready_o=1; a sample before any load gives dato_o=0.
//  2 Load 16 coefs -99,65,136,33,-156,-86,376,854,854,376,-86,-156,33,136,65,-99.
//    Strobes held ~868 cycles each -> exactly 16 writes; coef_done_o pulses once.
//    SHIFT=0, impulse 1 then 15 zeros -> dato_o sequence = coefficient list.
//  3 Step: SHIFT=4, 16+ samples of 100 -> settled dato_o = 2246*100>>>4 = 14037.
//    dato_valid_o is 17 cycles after each accept.
//  4 Saturation: samples of 2047 -> dato_o=32767. Samples of -2048 -> dato_o=-32768.
//  5 Swap during MAC: finish a load while k=5 -> that result uses the old bank, the next uses the new bank.
//    Restart load at idx=7 -> no coef_done_o until 16 further writes.
//  6 Overrun: sample_valid_i 3 cycles after accept -> overrun_o=1, sample dropped, next dato_o unchanged vs golden model.

Source files
------------

// File: rtl/fir_mac_coef_bank.sv
// fir_mac_coef_bank: time-multiplexed FIR filter, one multiplier and one
// accumulator, TAPS MAC cycles per sample, with a double-buffered coefficient
// bank that loads serially while the active bank keeps filtering.
//
// Ports
//   clk_100MHz_i          system clock, rising edge
//   rst_i                 asynchronous reset, active low
//   pulsador_carga_coef_i rising edge starts/restarts a coefficient load
//   cambio_coef_i         rising edge writes coef_in into the shadow bank
//   coef_in               signed coefficient value
//   sample_valid_i        1-cycle sample strobe
//   sample_i              signed input sample
//   ready_o               1 = next sample_valid_i is accepted
//   dato_o                signed filtered sample, held until next result
//   dato_valid_o          1-cycle strobe with each new dato_o
//   loading_o             1 while a coefficient load is in progress
//   coef_done_o           1-cycle strobe when the new bank becomes active
//   overrun_o             sticky: sample arrived while ready_o = 0
module fir_mac_coef_bank #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned COEF_W = 12,
  parameter int unsigned TAPS   = 16,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned SHIFT  = 4
) (
  input  logic                     clk_100MHz_i,
  input  logic                     rst_i,
  input  logic                     pulsador_carga_coef_i,
  input  logic                     cambio_coef_i,
  input  logic signed [COEF_W-1:0] coef_in,
  input  logic                     sample_valid_i,
  input  logic signed [DATA_W-1:0] sample_i,
  output logic                     ready_o,
  output logic signed [OUT_W-1:0]  dato_o,
  output logic                     dato_valid_o,
  output logic                     loading_o,
  output logic                     coef_done_o,
  output logic                     overrun_o
);

  localparam int unsigned IDX_W  = $clog2(TAPS);
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  // Output clamp bounds expressed at accumulator width
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} mac_state_t;
  typedef enum logic {L_IDLE, L_LOAD} load_state_t;

  mac_state_t  state_q, state_d;
  load_state_t l_state_q, l_state_d;

  logic                     load_prev_q, cambio_prev_q;
  logic                     load_evt_c, cambio_evt_c;
  logic                     restart_c, wr_en_c, last_wr_c;
  logic                     accept_c, swap_c;
  logic [IDX_W-1:0]         idx_q;
  logic [IDX_W-1:0]         k_q;
  logic                     swap_pend_q;
  logic signed [COEF_W-1:0] shadow_q [TAPS];
  logic signed [COEF_W-1:0] h_q      [TAPS];
  logic signed [DATA_W-1:0] x_q      [TAPS];
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  shifted_c;
  logic signed [OUT_W-1:0]  sat_c;

  // Rising-edge events on the two strobe inputs; a held level fires once
  assign load_evt_c   = pulsador_carga_coef_i & ~load_prev_q;
  assign cambio_evt_c = cambio_coef_i & ~cambio_prev_q;

  // Bank swap only while no sample is being filtered
  assign swap_c = swap_pend_q && (state_q == S_IDLE);

  // h[0] pairs with the newest sample
  assign prod_c    = PROD_W'(x_q[k_q]) * PROD_W'(h_q[k_q]);
  assign shifted_c = acc_q >>> SHIFT;

  // Saturate scaled accumulator into output range
  always_comb begin
    sat_c = OUT_W'(shifted_c);
    if (shifted_c > SAT_MAX) begin
      sat_c = OUT_W'(SAT_MAX);
    end else if (shifted_c < SAT_MIN) begin
      sat_c = OUT_W'(SAT_MIN);
    end
  end

  // State registers for both FSMs
  always_ff @(posedge clk_100MHz_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      l_state_q <= L_IDLE;
    end else begin
      state_q   <= state_d;
      l_state_q <= l_state_d;
    end
  end

  // Load FSM next state; a new load edge always wins over a write edge
  always_comb begin
    l_state_d = l_state_q;
    restart_c = 1'b0;
    wr_en_c   = 1'b0;
    last_wr_c = 1'b0;
    case (l_state_q)
      L_IDLE: begin
        if (load_evt_c) begin
          l_state_d = L_LOAD;
          restart_c = 1'b1;
        end
      end
      L_LOAD: begin
        if (load_evt_c) begin
          restart_c = 1'b1;
        end else if (cambio_evt_c) begin
          wr_en_c = 1'b1;
          if (idx_q == LAST_IDX) begin
            last_wr_c = 1'b1;
            l_state_d = L_IDLE;
          end
        end
      end
      default: l_state_d = L_IDLE;
    endcase
  end

  // MAC FSM next state
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sample_valid_i) begin
          accept_c = 1'b1;
          state_d  = S_MAC;
        end
      end
      S_MAC: begin
        if (k_q == LAST_IDX) begin
          state_d = S_OUT;
        end
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Coefficient banks, load index and swap handshake
  always_ff @(posedge clk_100MHz_i or negedge rst_i) begin
    if (!rst_i) begin
      load_prev_q   <= 1'b0;
      cambio_prev_q <= 1'b0;
      idx_q         <= '0;
      swap_pend_q   <= 1'b0;
      loading_o     <= 1'b0;
      coef_done_o   <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        shadow_q[i] <= '0;
        h_q[i]      <= '0;
      end
    end else begin
      load_prev_q   <= pulsador_carga_coef_i;
      cambio_prev_q <= cambio_coef_i;
      loading_o     <= (l_state_d == L_LOAD);
      coef_done_o   <= swap_c;
      if (restart_c) begin
        idx_q <= '0;
      end else if (wr_en_c) begin
        shadow_q[idx_q] <= coef_in;
        idx_q           <= idx_q + IDX_W'(1);
      end
      // A completing write outranks a swap in the same cycle so it is not lost
      if (last_wr_c) begin
        swap_pend_q <= 1'b1;
      end else if (swap_c) begin
        swap_pend_q <= 1'b0;
      end
      if (swap_c) begin
        for (int i = 0; i < TAPS; i++) begin
          h_q[i] <= shadow_q[i];
        end
      end
    end
  end

  // Delay line, accumulator and result outputs
  always_ff @(posedge clk_100MHz_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q        <= '0;
      k_q          <= '0;
      ready_o      <= 1'b1;
      dato_o       <= '0;
      dato_valid_o <= 1'b0;
      overrun_o    <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
      end
    end else begin
      ready_o      <= (state_d == S_IDLE);
      dato_valid_o <= (state_q == S_OUT);
      if (sample_valid_i && !ready_o) begin
        overrun_o <= 1'b1;
      end
      if (accept_c) begin
        x_q[0] <= sample_i;
        for (int i = 1; i < TAPS; i++) begin
          x_q[i] <= x_q[i-1];
        end
        acc_q <= '0;
        k_q   <= '0;
      end else if (state_q == S_MAC) begin
        acc_q <= acc_q + ACC_W'(prod_c);
        k_q   <= k_q + IDX_W'(1);
      end
      if (state_q == S_OUT) begin
        dato_o <= sat_c;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_coef_bank.sv
// Self-checking bench for fir_mac_coef_bank. Two instances share stimulus:
// u_dut uses SHIFT=4, u_dut0 uses SHIFT=0. Expected results are pushed to a
// scoreboard when a sample is driven and popped when dato_valid_o appears.
module tb_fir_mac_coef_bank;

  localparam int TAPS = 16;

  logic               clk;
  logic               rst_n;
  logic               pulsador;
  logic               cambio;
  logic signed [11:0] coef_in;
  logic               sample_valid;
  logic signed [11:0] sample;

  logic               ready_o, dato_valid_o, loading_o, coef_done_o, overrun_o;
  logic signed [15:0] dato_o;
  logic               ready0_o, dato0_valid_o, loading0_o, coef_done0_o, overrun0_o;
  logic signed [15:0] dato0_o;

  fir_mac_coef_bank u_dut (
    .clk_100MHz_i          (clk),
    .rst_i                 (rst_n),
    .pulsador_carga_coef_i (pulsador),
    .cambio_coef_i         (cambio),
    .coef_in               (coef_in),
    .sample_valid_i        (sample_valid),
    .sample_i              (sample),
    .ready_o               (ready_o),
    .dato_o                (dato_o),
    .dato_valid_o          (dato_valid_o),
    .loading_o             (loading_o),
    .coef_done_o           (coef_done_o),
    .overrun_o             (overrun_o)
  );

  fir_mac_coef_bank #(.SHIFT(0)) u_dut0 (
    .clk_100MHz_i          (clk),
    .rst_i                 (rst_n),
    .pulsador_carga_coef_i (pulsador),
    .cambio_coef_i         (cambio),
    .coef_in               (coef_in),
    .sample_valid_i        (sample_valid),
    .sample_i              (sample),
    .ready_o               (ready0_o),
    .dato_o                (dato0_o),
    .dato_valid_o          (dato0_valid_o),
    .loading_o             (loading0_o),
    .coef_done_o           (coef_done0_o),
    .overrun_o             (overrun0_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int e4;
    int e0;
    int cyc;
  } exp_t;

  typedef struct {
    logic signed [11:0] sample;
    int                 e4;
    int                 e0;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[36];

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  int h_a[16] = '{-99, 65, 136, 33, -156, -86, 376, 854,
                  854, 376, -86, -156, 33, 136, 65, -99};
  int h_b[16];
  int coefs_ld[16];
  int bank_m[16];
  int x_m[16];

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int sat16(input int a);
    if (a > 32767) return 32767;
    if (a < -32768) return -32768;
    return a;
  endfunction

  function automatic int model_out(input int sh);
    int acc = 0;
    for (int k = 0; k < TAPS; k++) acc += x_m[k] * bank_m[k];
    return sat16(acc >>> sh);
  endfunction

  task automatic shift_model(input int v);
    for (int k = TAPS - 1; k > 0; k--) x_m[k] = x_m[k-1];
    x_m[0] = v;
  endtask

  // Advance one cycle; results are checked at the falling edge, inputs move 1ns later
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (coef_done_o) done_cnt++;
    if (dato_valid_o || dato0_valid_o) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("valid_sh4", int'(dato_valid_o), 1);
        check("valid_sh0", int'(dato0_valid_o), 1);
        check("dato_sh4", int'(dato_o), e.e4);
        check("dato_sh0", int'(dato0_o), e.e0);
        check("latency_cycle", cyc, e.cyc);
      end
    end
    #1;
  endtask

  task automatic drive_sample(input int v, input int e4, input int e0);
    exp_t e;
    check("ready_at_drive", int'(ready_o), 1);
    e.e4  = e4;
    e.e0  = e0;
    e.cyc = cyc + TAPS + 2;
    sb.push_back(e);
    sample       = 12'(v);
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic wait_results();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL result_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic send_m(input int v);
    shift_model(v);
    drive_sample(v, model_out(4), model_out(0));
    wait_results();
  endtask

  // which: 0 = load button, 1 = write strobe
  task automatic pulse(input int which, input int hold);
    if (which == 0) pulsador = 1'b1;
    else cambio = 1'b1;
    repeat (hold) step();
    pulsador = 1'b0;
    cambio   = 1'b0;
    repeat (hold) step();
  endtask

  task automatic load_bank(input int hold);
    pulse(0, hold);
    check("loading_after_start", int'(loading_o), 1);
    for (int i = 0; i < TAPS; i++) begin
      coef_in = 12'(coefs_ld[i]);
      pulse(1, hold);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, int'(ready_o), 1);
    check({tag, "_dato"}, int'(dato_o), 0);
    check({tag, "_dato_valid"}, int'(dato_valid_o), 0);
    check({tag, "_loading"}, int'(loading_o), 0);
    check({tag, "_coef_done"}, int'(coef_done_o), 0);
    check({tag, "_overrun"}, int'(overrun_o), 0);
  endtask

  initial begin
    int ps;
    int done_before;

    // Vector table: impulse response then step response
    for (int i = 0; i < 16; i++) begin
      vecs[i].sample = (i == 0) ? 12'sd1 : 12'sd0;
      vecs[i].e0     = h_a[i];
      vecs[i].e4     = h_a[i] >>> 4;
    end
    ps = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) ps += h_a[i];
      vecs[16+i].sample = 12'sd100;
      if (i >= 15) begin
        vecs[16+i].e4 = 14037;
        vecs[16+i].e0 = 32767;
      end else begin
        vecs[16+i].e4 = sat16((100 * ps) >>> 4);
        vecs[16+i].e0 = sat16(100 * ps);
      end
    end
    for (int i = 0; i < 16; i++) begin
      h_b[i]    = 40 * i - 300;
      bank_m[i] = 0;
      x_m[i]    = 0;
    end

    rst_n        = 1'b0;
    pulsador     = 1'b0;
    cambio       = 1'b0;
    coef_in      = '0;
    sample_valid = 1'b0;
    sample       = '0;

    // Reset state
    repeat (10) step();
    check_idle_outputs("in_reset");
    rst_n = 1'b1;
    step();
    check_idle_outputs("after_reset");

    // Reset mid-MAC aborts the sample with no result
    sample       = 12'sd500;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    repeat (5) step();
    check("ready_mid_mac", int'(ready_o), 0);
    rst_n = 1'b0;
    step();
    check_idle_outputs("mid_mac_reset");
    repeat (9) step();
    rst_n = 1'b1;
    repeat (25) step();

    // Zero bank before any load
    send_m(500);
    check("no_load_zero", int'(dato_o), 0);

    // Slow held-strobe load of the reference bank
    coefs_ld = h_a;
    load_bank(868);
    check("load_done_count", done_cnt, 1);
    check("loading_after_load", int'(loading_o), 0);
    bank_m = h_a;

    // Flush, then impulse and step tables
    repeat (15) send_m(0);
    for (int i = 0; i < 36; i++) begin
      shift_model(int'(vecs[i].sample));
      drive_sample(int'(vecs[i].sample), vecs[i].e4, vecs[i].e0);
      wait_results();
    end

    // Saturation both directions
    repeat (17) send_m(2047);
    check("sat_pos_sh4", int'(dato_o), 32767);
    check("sat_pos_sh0", int'(dato0_o), 32767);
    repeat (17) send_m(-2048);
    check("sat_neg_sh4", int'(dato_o), -32768);
    check("sat_neg_sh0", int'(dato0_o), -32768);
    repeat (4) send_m(321);

    // Restarted load, then completion during MAC
    done_before = done_cnt;
    pulse(0, 1);
    coef_in = 12'sd1000;
    repeat (7) pulse(1, 1);
    pulse(0, 1);
    for (int i = 0; i < 15; i++) begin
      coef_in = 12'(h_b[i]);
      pulse(1, 1);
    end
    check("restart_no_done", done_cnt, done_before);
    check("restart_still_loading", int'(loading_o), 1);
    shift_model(300);
    drive_sample(300, model_out(4), model_out(0));
    repeat (4) step();
    coef_in = 12'(h_b[15]);
    cambio  = 1'b1;
    step();
    cambio  = 1'b0;
    step();
    wait_results();
    check("swap_deferred", done_cnt, done_before);
    check("loading_after_mac_load", int'(loading_o), 0);
    bank_m = h_b;
    send_m(-200);
    check("swap_done", done_cnt, done_before + 1);
    send_m(700);
    send_m(-1234);

    // Overrun: sample 3 cycles after accept is dropped
    check("overrun_clear", int'(overrun_o), 0);
    shift_model(250);
    drive_sample(250, model_out(4), model_out(0));
    step();
    step();
    check("ready_busy", int'(ready_o), 0);
    sample       = -12'sd1500;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    wait_results();
    check("overrun_set", int'(overrun_o), 1);
    send_m(-50);
    check("overrun_sticky", int'(overrun_o), 1);

    // Reset clears sticky flag and held output
    rst_n = 1'b0;
    repeat (3) step();
    check_idle_outputs("final_reset");
    rst_n = 1'b1;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
